// File: rtl/ap_mult_pipe.sv
// ap_mult_pipe: two-stage unsigned multiplier with an exact and an OR-approximated low-column product.
// S1 keeps the upper columns' exact sum plus the low columns' exact sum and OR vector; S2 keeps the selected sum.
module ap_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 5,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 p_mode,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     err_cnt
);
  localparam int PW = 2 * WIDTH;
  logic          w_en;
  logic [PW-1:0] w_hi, w_lo, w_or, w_ex, w_ap;
  logic          r_v1, r_m1, r_v2, r_m2, r_diff;
  logic [PW-1:0] r_hi, r_lo, r_or, r_p;
  logic [CNT_W-1:0] r_cnt;
  assign w_en      = !r_v2 | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v2;
  assign p         = r_p;
  assign p_mode    = r_m2;
  assign err_cnt   = r_cnt;
  always_comb begin
    w_hi = '0;
    w_lo = '0;
    w_or = '0;
    for (int j = 0; j < WIDTH; j++)
      for (int i = 0; i < WIDTH; i++)
        if (a[i] & b[j]) begin
          if (i + j >= APPROX_COLS) w_hi = w_hi + (PW'(1) << (i + j));
          else begin
            w_lo = w_lo + (PW'(1) << (i + j));
            w_or = w_or | (PW'(1) << (i + j));
          end
        end
  end
  // OR'd low columns never carry, so the approximate sum cannot exceed the exact one
  assign w_ex = r_hi + r_lo;
  assign w_ap = r_hi + r_or;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_m1   <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_or   <= '0;
      r_v2   <= 1'b0;
      r_m2   <= 1'b0;
      r_diff <= 1'b0;
      r_p    <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_en) begin
        r_v1   <= in_valid;
        r_m1   <= mode;
        r_hi   <= w_hi;
        r_lo   <= w_lo;
        r_or   <= w_or;
        r_v2   <= r_v1;
        r_m2   <= r_m1;
        r_diff <= w_ap != w_ex;
        r_p    <= r_m1 ? w_ap : w_ex;
      end
      if (clr_cnt) r_cnt <= '0;
      else if (r_v2 & out_ready & r_m2 & r_diff & ~&r_cnt) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule
